// File: rtl/digital_channel_ctrl_if.sv
// Event output bus: FIFO head with valid/ready pop handshake.
interface digital_channel_ctrl_if #(
    parameter int ADCBITS = 10,
    parameter int TS_BITS = 16
);
    logic [TS_BITS+ADCBITS-1:0] event_data;
    logic                       event_valid;
    logic                       event_ready;

    modport master (output event_data, output event_valid, input event_ready);
    modport slave  (input event_data, input event_valid, output event_ready);
endinterface

// File: rtl/digital_channel_ctrl.sv
// Front-end channel controller: synchronized trigger, hold/sample/convert sequencing
// of an external ADC, and a first-word-fall-through event FIFO.
module digital_channel_ctrl #(
    parameter int ADCBITS    = 10,
    parameter int TS_BITS    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 63
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hit,
    input  logic                done,
    input  logic [ADCBITS-1:0]  dout,
    input  logic                enable,
    input  logic                external_trigger,
    input  logic [3:0]          hold_delay,
    input  logic [3:0]          reset_cycles,
    input  logic [TS_BITS-1:0]  timestamp,
    output logic                sample,
    output logic                csa_reset,
    digital_channel_ctrl_if.master evt,
    output logic                fifo_overflow,
    output logic                conv_timeout
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_RESET_CSA = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_HOLD      = 3'd2;
    localparam logic [2:0] S_SAMPLE    = 3'd3;
    localparam logic [2:0] S_CONVERT   = 3'd4;
    localparam logic [2:0] S_STORE     = 3'd5;

    logic                      r_hit_meta, r_hit_s, r_done_meta, r_done_s;
    logic [2:0]                r_state;
    logic [3:0]                r_cnt;
    logic [TW-1:0]             r_tmo;
    logic                      r_sample, r_csa_reset, r_conv_timeout, r_fifo_overflow;
    logic [TS_BITS-1:0]        r_ts;
    logic [ADCBITS-1:0]        r_adc;
    logic [TS_BITS+ADCBITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]             r_wr, r_rd;
    logic [CW-1:0]             r_count;

    logic [3:0] w_rc_min;
    logic       w_trigger, w_push, w_pop, w_push_ok;

    assign w_rc_min  = (reset_cycles == 4'd0) ? 4'd1 : reset_cycles;
    assign w_trigger = enable && (r_hit_s || external_trigger);
    assign w_push    = (r_state == S_STORE);
    assign w_pop     = (r_count != '0) && evt.event_ready;
    assign w_push_ok = w_push && ((r_count < CW'(FIFO_DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_meta  <= 1'b0;
            r_hit_s     <= 1'b0;
            r_done_meta <= 1'b0;
            r_done_s    <= 1'b0;
        end else begin
            r_hit_meta  <= hit;
            r_hit_s     <= r_hit_meta;
            r_done_meta <= done;
            r_done_s    <= r_done_meta;
        end
    end

    // sample/csa_reset are set on the transition into their state so they stay registered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_RESET_CSA;
            r_cnt          <= w_rc_min;
            r_tmo          <= '0;
            r_sample       <= 1'b0;
            r_csa_reset    <= 1'b1;
            r_conv_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_RESET_CSA: begin
                    if (r_cnt <= 4'd1) begin
                        r_state     <= S_IDLE;
                        r_csa_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_IDLE: begin
                    if (w_trigger) begin
                        r_ts <= timestamp;
                        if (hold_delay == 4'd0) begin
                            r_state  <= S_SAMPLE;
                            r_sample <= 1'b1;
                            r_cnt    <= 4'd1;
                        end else begin
                            r_state <= S_HOLD;
                            r_cnt   <= hold_delay;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_cnt <= 4'd1) begin
                        r_state  <= S_SAMPLE;
                        r_sample <= 1'b1;
                        r_cnt    <= 4'd1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= S_CONVERT;
                        r_sample <= 1'b0;
                        r_tmo    <= '0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_CONVERT: begin
                    if (r_done_s) begin
                        r_adc   <= dout;
                        r_state <= S_STORE;
                    end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                        r_conv_timeout <= 1'b1;
                        r_state        <= S_RESET_CSA;
                        r_csa_reset    <= 1'b1;
                        r_cnt          <= w_rc_min;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_STORE: begin
                    r_state     <= S_RESET_CSA;
                    r_csa_reset <= 1'b1;
                    r_cnt       <= w_rc_min;
                end
                default: begin
                    r_state     <= S_RESET_CSA;
                    r_sample    <= 1'b0;
                    r_csa_reset <= 1'b1;
                    r_cnt       <= w_rc_min;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr] <= {r_ts, r_adc};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr            <= '0;
            r_rd            <= '0;
            r_count         <= '0;
            r_fifo_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr <= (r_wr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr + PW'(1);
            if (w_pop)     r_rd <= (r_rd == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd + PW'(1);
            if (w_push && !w_push_ok) r_fifo_overflow <= 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign evt.event_data  = r_mem[r_rd];
    assign evt.event_valid = (r_count != '0);
    assign sample          = r_sample;
    assign csa_reset       = r_csa_reset;
    assign fifo_overflow   = r_fifo_overflow;
    assign conv_timeout    = r_conv_timeout;
endmodule

// File: tb/tb_digital_channel_ctrl.sv
// Directed bench for digital_channel_ctrl: stimulus pushes expected events into a
// queue, a negedge monitor pops and compares on every FIFO handshake.
module tb_digital_channel_ctrl;
    logic        clk;
    logic        reset, hit, done, enable, external_trigger;
    logic [9:0]  dout;
    logic [3:0]  hold_delay, reset_cycles;
    logic [15:0] timestamp;
    logic        sample, csa_reset, fifo_overflow, conv_timeout;

    int n_checks = 0;
    int n_pass   = 0;
    logic [25:0] exp_q[$];

    digital_channel_ctrl_if #(.ADCBITS(10), .TS_BITS(16)) bus ();

    digital_channel_ctrl #(
        .ADCBITS(10), .TS_BITS(16), .FIFO_DEPTH(4), .TIMEOUT(63)
    ) dut (
        .clk(clk), .reset(reset), .hit(hit), .done(done), .dout(dout),
        .enable(enable), .external_trigger(external_trigger),
        .hold_delay(hold_delay), .reset_cycles(reset_cycles), .timestamp(timestamp),
        .sample(sample), .csa_reset(csa_reset), .evt(bus),
        .fifo_overflow(fifo_overflow), .conv_timeout(conv_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timestamp advances on negedge so every posedge sees a stable value.
    always @(negedge clk) timestamp = timestamp + 16'd1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endfunction

    int  s_run = 0, c_run = 0, c_exp = 0;
    bit  rst_seen = 0;
    logic [25:0] head;

    always @(negedge clk) begin
        chk("excl", {31'd0, sample & csa_reset}, 32'd0);
        if (reset) rst_seen = 1;
        if (csa_reset) begin
            if (c_run == 0) c_exp = (reset_cycles == 4'd0) ? 1 : int'(reset_cycles);
            c_run++;
        end else if (c_run > 0) begin
            if (!rst_seen) chk("csa_len", c_run, c_exp);
            c_run    = 0;
            rst_seen = 0;
        end
        if (sample) s_run++;
        else if (s_run > 0) begin
            chk("sample_len", s_run, 2);
            s_run = 0;
        end
        if (bus.event_valid === 1'b1 && bus.event_ready === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_event", {6'd0, bus.event_data}, 32'hFFFFFFFF);
            else begin
                head = exp_q.pop_front();
                chk("event_data", {6'd0, bus.event_data}, {6'd0, head});
            end
        end
    end

    task automatic wait_ts(input logic [15:0] v);
        int n = 0;
        while (timestamp !== v && n < 1000) begin @(posedge clk); #1; n++; end
        chk("wait_ts", {16'd0, timestamp}, {16'd0, v});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (csa_reset !== 1'b0 && n < 200) begin @(posedge clk); #1; n++; end
        chk("wait_idle", {31'd0, csa_reset}, 32'd0);
    endtask

    // Called at posedge+1 with the FSM idle; latched ts is +1 edge (ext) or +3 edges (hit).
    task automatic run_event(input bit use_hit, input logic [9:0] d, input int dly,
                             input bit expect_store, input bit pop_at_store);
        logic [15:0] t;
        int n;
        t = timestamp;
        if (use_hit) begin
            hit = 1'b1;
            repeat (3) @(posedge clk);
            #1 hit = 1'b0;
            t = t + 16'd3;
        end else begin
            external_trigger = 1'b1;
            @(posedge clk);
            #1 external_trigger = 1'b0;
            t = t + 16'd1;
        end
        n = 0;
        while (sample !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        chk("hold_len", n, int'(hold_delay));
        n = 0;
        while (sample !== 1'b0 && n < 10) begin @(posedge clk); #1; n++; end
        chk("sample_fall", {31'd0, sample}, 32'd0);
        repeat (dly) @(posedge clk);
        #1;
        done = 1'b1;
        dout = d;
        if (expect_store) exp_q.push_back({t, d});
        repeat (3) @(posedge clk);
        #1;
        if (pop_at_store) bus.event_ready = 1'b1;
        @(posedge clk);
        #1;
        if (pop_at_store) bus.event_ready = 1'b0;
        done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        int n;
        timestamp = 16'd0;
        reset = 1'b1; hit = 1'b0; done = 1'b0; dout = '0; enable = 1'b1;
        external_trigger = 1'b0; hold_delay = 4'd0; reset_cycles = 4'd2;
        bus.event_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_csa", {31'd0, csa_reset}, 32'd1);
        chk("rst_sample", {31'd0, sample}, 32'd0);
        chk("rst_valid", {31'd0, bus.event_valid}, 32'd0);
        chk("rst_ovf", {31'd0, fifo_overflow}, 32'd0);
        chk("rst_tmo", {31'd0, conv_timeout}, 32'd0);
        reset = 1'b0;
        wait_idle();
        bus.event_ready = 1'b1;

        // External trigger, hold_delay 0: event ts 0x0040
        hold_delay = 4'd0;
        wait_ts(16'h003F);
        run_event(1'b0, 10'h2C3, 2, 1'b1, 1'b0);
        wait_idle();

        // Hit raised while ts 100 visible: latched ts 103
        hold_delay = 4'd3;
        wait_ts(16'd100);
        run_event(1'b1, 10'h1A5, 5, 1'b1, 1'b0);
        wait_idle();

        // reset_cycles 0 behaves as 1
        reset_cycles = 4'd0;
        run_event(1'b0, 10'h055, 0, 1'b1, 1'b0);
        wait_idle();
        reset_cycles = 4'd2;

        // Masked trigger
        enable = 1'b0;
        hit = 1'b1;
        seen = 0;
        repeat (10) begin @(posedge clk); #1; if (sample === 1'b1) seen = 1; end
        chk("mask_sample", {31'd0, seen}, 32'd0);
        hit = 1'b0;
        repeat (4) @(posedge clk);
        #1 enable = 1'b1;

        // Enable dropped during HOLD: event completes
        hold_delay = 4'd5;
        fork
            run_event(1'b0, 10'h3C7, 1, 1'b1, 1'b0);
            begin repeat (2) @(posedge clk); #1 enable = 1'b0; end
        join
        wait_idle();
        enable = 1'b1;

        // Overflow: 4 stored, 5th dropped, 6th accepted via same-cycle pop
        bus.event_ready = 1'b0;
        hold_delay = 4'd1;
        for (int i = 0; i < 4; i++) begin
            run_event(1'b0, 10'h100 + 10'(i), 1, 1'b1, 1'b0);
            wait_idle();
        end
        chk("ovf_full_no_drop", {31'd0, fifo_overflow}, 32'd0);
        run_event(1'b0, 10'h3FF, 1, 1'b0, 1'b0);
        wait_idle();
        chk("ovf_set", {31'd0, fifo_overflow}, 32'd1);
        chk("ovf_valid", {31'd0, bus.event_valid}, 32'd1);
        run_event(1'b0, 10'h2AA, 1, 1'b1, 1'b1);
        wait_idle();
        bus.event_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("drain_empty", {31'd0, bus.event_valid}, 32'd0);

        // Conversion timeout after 63 CONVERT cycles
        hold_delay = 4'd0;
        external_trigger = 1'b1;
        @(posedge clk);
        #1 external_trigger = 1'b0;
        n = 0;
        while (sample !== 1'b0 && n < 10) begin @(posedge clk); #1; n++; end
        repeat (62) @(posedge clk);
        #1;
        chk("tmo_early", {31'd0, conv_timeout}, 32'd0);
        @(posedge clk);
        #1;
        chk("tmo_set", {31'd0, conv_timeout}, 32'd1);
        chk("tmo_csa", {31'd0, csa_reset}, 32'd1);
        wait_idle();

        // Reset during CONVERT with one event buffered
        bus.event_ready = 1'b0;
        run_event(1'b0, 10'h0F0, 1, 1'b1, 1'b0);
        wait_idle();
        chk("pre_rst_valid", {31'd0, bus.event_valid}, 32'd1);
        external_trigger = 1'b1;
        @(posedge clk);
        #1 external_trigger = 1'b0;
        n = 0;
        while (sample !== 1'b0 && n < 10) begin @(posedge clk); #1; n++; end
        done = 1'b1;
        dout = 10'h1EE;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        done = 1'b0;
        chk("mid_rst_csa", {31'd0, csa_reset}, 32'd1);
        chk("mid_rst_valid", {31'd0, bus.event_valid}, 32'd0);
        chk("mid_rst_ovf", {31'd0, fifo_overflow}, 32'd0);
        chk("mid_rst_tmo", {31'd0, conv_timeout}, 32'd0);
        bus.event_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("post_rst_valid", {31'd0, bus.event_valid}, 32'd0);

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
